// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if
//   Bundles the execute-stage request/response handshake and the word-memory
//   port of the load/store initiator.
//   master modport: the LSU side (drives req_ready, resp_*, mem_wren/rden/addr/d).
//   slave  modport: the surroundings (drive req_*, supply mem_q).
//   Parameter MEM_ADDRSIZE: word-address width of the attached memory.
interface lsu_mem_master_if #(
    parameter int MEM_ADDRSIZE = 10
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [2:0]              req_funct3;
    logic [63:0]             req_addr;
    logic [63:0]             req_wdata;
    logic                    resp_valid;
    logic [63:0]             resp_rdata;
    logic                    resp_err;
    logic                    mem_wren;
    logic                    mem_rden;
    logic [MEM_ADDRSIZE-1:0] mem_addr;
    logic [63:0]             mem_d;
    logic [63:0]             mem_q;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_wren, mem_rden, mem_addr, mem_d
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_wren, mem_rden, mem_addr, mem_d
    );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   RV64 load/store initiator for a single-port 64-bit word memory.
//   Sub-doubleword stores are read-modify-write; loads are sign/zero extended.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - lsu_mem_master_if.master: req_*/resp_* handshake and mem_* port
//   Parameter MEM_ADDRSIZE: word-address width; byte address bits
//     [MEM_ADDRSIZE+2:3] select the word, higher bits wrap.
//   Optional feature macro LSU_MISALIGN_TRAP_EN:
//     defined   - misaligned accesses complete with resp_err and no memory access
//     undefined - low address bits are forced to natural alignment
module lsu_mem_master #(
    parameter int MEM_ADDRSIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_mem_master_if.master     bus
);
    localparam int AW = MEM_ADDRSIZE + 3;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [63:0]     word_q, word_d;
    logic            err_q, err_d;

    logic [2:0]      align_mask;
    logic            req_illegal;
    logic            req_err;
    logic [AW-1:0]   req_addr_eff;
    logic            unused_addr_bits;

    logic [5:0]      lane_shift;
    logic [63:0]     lane_word;
    logic [63:0]     size_mask;
    logic [63:0]     load_ext;
    logic [63:0]     merged_word;

    // Address bits above the memory window are deliberately ignored.
    assign unused_addr_bits = ^bus.req_addr[63:AW];

    // Decode an incoming request: illegal funct3, and either trap or
    // silently align a misaligned address.
    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        req_illegal = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
        req_err      = req_illegal | (|(bus.req_addr[2:0] & align_mask));
        req_addr_eff = bus.req_addr[AW-1:0];
`else
        req_err      = req_illegal;
        req_addr_eff = {bus.req_addr[AW-1:3], bus.req_addr[2:0] & ~align_mask};
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Full doubleword stores need no read, so skip RD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (bus.req_we && (bus.req_funct3[1:0] == 2'b11)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request and sampled-word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 64'h0;
            word_q   <= 64'h0;
            err_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            err_q    <= err_d;
        end
    end

    // Capture the request on acceptance; latch mem_q at the end of RD.
    always_comb begin
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        err_d    = err_q;
        if (state_q == IDLE && bus.req_valid) begin
            we_d     = bus.req_we;
            funct3_d = bus.req_funct3;
            addr_d   = req_addr_eff;
            wdata_d  = bus.req_wdata;
            err_d    = req_err;
        end
        if (state_q == RD) begin
            word_d = bus.mem_q;
        end
    end

    // Lane extraction for loads and byte merge for stores, both keyed by
    // the byte offset within the sampled word.
    always_comb begin
        lane_shift = {addr_q[2:0], 3'b000};
        lane_word  = word_q >> lane_shift;
        case (funct3_q[1:0])
            2'b00: begin
                size_mask = 64'h0000_0000_0000_00FF;
                load_ext  = {{56{~funct3_q[2] & lane_word[7]}}, lane_word[7:0]};
            end
            2'b01: begin
                size_mask = 64'h0000_0000_0000_FFFF;
                load_ext  = {{48{~funct3_q[2] & lane_word[15]}}, lane_word[15:0]};
            end
            2'b10: begin
                size_mask = 64'h0000_0000_FFFF_FFFF;
                load_ext  = {{32{~funct3_q[2] & lane_word[31]}}, lane_word[31:0]};
            end
            default: begin
                size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                load_ext  = lane_word;
            end
        endcase
        merged_word = (word_q & ~(size_mask << lane_shift))
                    | ((wdata_q & size_mask) << lane_shift);
    end

    // Outputs decode from the state register and registered request only.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.mem_rden   = (state_q == RD);
        bus.mem_wren   = (state_q == WR);
        bus.mem_addr   = addr_q[AW-1:3];
        bus.mem_d      = (state_q == WR) ? merged_word : 64'h0;
        bus.resp_valid = (state_q == RESP);
        bus.resp_err   = (state_q == RESP) && err_q;
        bus.resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? load_ext : 64'h0;
    end
endmodule
